// File: rtl/writeback_stage_if.sv
// rtl/writeback_stage_if.sv - upstream result, memory response and register-file write bundle for writeback_stage
interface writeback_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_regWrite;
  logic [4:0]  in_rd;
  logic        in_isLoad;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic [31:0] in_result;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        regWrite;
  logic [4:0]  writereg;
  logic [31:0] writedata;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic        load_timeout;

  modport master (
    output in_valid, in_regWrite, in_rd, in_isLoad, in_funct3, in_addr_lo, in_result,
    output mem_rvalid, mem_rdata,
    input  in_ready, regWrite, writereg, writedata, fwd_valid, fwd_rd, fwd_data, load_timeout
  );

  modport slave (
    input  in_valid, in_regWrite, in_rd, in_isLoad, in_funct3, in_addr_lo, in_result,
    input  mem_rvalid, mem_rdata,
    output in_ready, regWrite, writereg, writedata, fwd_valid, fwd_rd, fwd_data, load_timeout
  );
endinterface

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - register-file writeback with load extraction and load-wait timeout
// Optional macro WB_FORWARD_EN mirrors the write port onto the decode-stage bypass outputs.
module writeback_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic             clk,
  input logic             reset,
  writeback_stage_if.slave wb
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, WAIT_LOAD} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    rd_q, rd_d;
  logic          we_q, we_d;
  logic [2:0]    f3_q, f3_d;
  logic [1:0]    alo_q, alo_d;
  logic          regwrite_q, regwrite_d;
  logic [4:0]    writereg_q, writereg_d;
  logic [31:0]   writedata_q, writedata_d;
  logic          timeout_q, timeout_d;

  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_data;
  logic          ld_ok;

  always_comb begin
    ld_byte = wb.mem_rdata[7:0];
    case (alo_q)
      2'd0: ld_byte = wb.mem_rdata[7:0];
      2'd1: ld_byte = wb.mem_rdata[15:8];
      2'd2: ld_byte = wb.mem_rdata[23:16];
      2'd3: ld_byte = wb.mem_rdata[31:24];
      default: ld_byte = wb.mem_rdata[7:0];
    endcase
    ld_half = alo_q[1] ? wb.mem_rdata[31:16] : wb.mem_rdata[15:0];
  end

  // Unsupported size codes still complete the handshake, just without a write.
  always_comb begin
    ld_data = 32'd0;
    ld_ok   = 1'b1;
    case (f3_q)
      3'b000: ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100: ld_data = {24'd0, ld_byte};
      3'b001: ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101: ld_data = {16'd0, ld_half};
      3'b010: ld_data = wb.mem_rdata;
      default: ld_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_d        = rd_q;
    we_d        = we_q;
    f3_d        = f3_q;
    alo_d       = alo_q;
    regwrite_d  = 1'b0;
    writereg_d  = writereg_q;
    writedata_d = writedata_q;
    timeout_d   = timeout_q;
    case (state_q)
      IDLE: begin
        if (wb.in_valid) begin
          if (wb.in_isLoad) begin
            rd_d    = wb.in_rd;
            we_d    = wb.in_regWrite;
            f3_d    = wb.in_funct3;
            alo_d   = wb.in_addr_lo;
            cnt_d   = '0;
            state_d = WAIT_LOAD;
          end else begin
            writereg_d  = wb.in_rd;
            writedata_d = wb.in_result;
            regwrite_d  = wb.in_regWrite && (wb.in_rd != 5'd0);
          end
        end
      end
      WAIT_LOAD: begin
        // Data arriving on the final wait cycle takes priority over the timeout.
        if (wb.mem_rvalid) begin
          writereg_d  = rd_q;
          writedata_d = ld_data;
          regwrite_d  = we_q && (rd_q != 5'd0) && ld_ok;
          state_d     = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rd_q        <= 5'd0;
      we_q        <= 1'b0;
      f3_q        <= 3'd0;
      alo_q       <= 2'd0;
      regwrite_q  <= 1'b0;
      writereg_q  <= 5'd0;
      writedata_q <= 32'd0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      we_q        <= we_d;
      f3_q        <= f3_d;
      alo_q       <= alo_d;
      regwrite_q  <= regwrite_d;
      writereg_q  <= writereg_d;
      writedata_q <= writedata_d;
      timeout_q   <= timeout_d;
    end
  end

  assign wb.in_ready     = (state_q == IDLE);
  assign wb.regWrite     = regwrite_q;
  assign wb.writereg     = writereg_q;
  assign wb.writedata    = writedata_q;
  assign wb.load_timeout = timeout_q;

`ifdef WB_FORWARD_EN
  assign wb.fwd_valid = regwrite_q;
  assign wb.fwd_rd    = writereg_q;
  assign wb.fwd_data  = writedata_q;
`else
  assign wb.fwd_valid = 1'b0;
  assign wb.fwd_rd    = 5'd0;
  assign wb.fwd_data  = 32'd0;
`endif

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255, giving the maximum number of cycles spent waiting for load data.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the upstream stage presents an instruction result.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept an instruction this cycle.
REQ-006 The block SHALL have ports in_regWrite (input, 1 bit), in_rd (input, 5 bits) and in_isLoad (input, 1 bit), carrying the instruction's write enable, destination register and load flag.
REQ-007 The block SHALL have ports in_funct3 (input, 3 bits) and in_addr_lo (input, 2 bits), carrying the load size/sign code and the low address bits.
REQ-008 The block SHALL have port in_result, input, 32 bits: the ALU result.
REQ-009 The block SHALL have ports mem_rvalid (input, 1 bit) and mem_rdata (input, 32 bits), carrying the data-memory response.
REQ-010 The block SHALL have ports regWrite (output, 1 bit), writereg (output, 5 bits) and writedata (output, 32 bits), driving the register-file write port.
REQ-011 The block SHALL have ports fwd_valid (output, 1 bit), fwd_rd (output, 5 bits) and fwd_data (output, 32 bits), carrying bypass information for the decode stage.
REQ-012 The block SHALL have port load_timeout, output, 1 bit: a sticky error flag.

Function
REQ-013 The block SHALL accept an instruction when in_valid=1 and in_ready=1 are sampled on the same rising edge.
REQ-014 The block SHALL implement exactly two states: IDLE (in_ready=1) and WAIT_LOAD (in_ready=0); in_ready SHALL be a decode of the state register only.
REQ-015 In IDLE, accepting a non-load SHALL register writereg=in_rd and writedata=in_result, assert regWrite for exactly the next cycle, and remain in IDLE, giving one-cycle latency and one instruction per cycle.
REQ-016 In IDLE, accepting a load SHALL capture in_rd, in_regWrite, in_funct3 and in_addr_lo, clear the wait counter, drive regWrite=0 the next cycle, and move to WAIT_LOAD.
REQ-017 In WAIT_LOAD with mem_rvalid=1, the block SHALL register the extracted load data, assert regWrite for exactly one cycle and return to IDLE; mem_rvalid sampled in IDLE SHALL be ignored.
REQ-018 Load extraction SHALL be: funct3 000 = sign-extended byte at addr_lo; 100 = zero-extended byte; 001 = sign-extended half selected by addr_lo[1]; 101 = zero-extended half; 010 = full word with addr_lo ignored.
REQ-019 Any other funct3 value on a load SHALL suppress the write (regWrite=0) while still completing the handshake.
REQ-020 regWrite SHALL be 0 whenever the captured in_regWrite=0 or the destination register is 0; the instruction is still consumed in these cases.
REQ-021 In WAIT_LOAD the wait counter SHALL increment each cycle without mem_rvalid; when it reaches TIMEOUT_CYCLES the block SHALL set load_timeout, drop the load with no write, and return to IDLE.
REQ-022 If mem_rvalid arrives in the same cycle the counter reaches its limit, the data SHALL win and load_timeout SHALL remain unchanged.
REQ-023 load_timeout SHALL stay 1 until reset.

Reset
REQ-024 Asserting reset SHALL immediately force: state=IDLE, regWrite=0, writereg=0, writedata=0, fwd_valid=0, fwd_rd=0, fwd_data=0, load_timeout=0, wait counter=0.
REQ-025 A reset asserted during WAIT_LOAD SHALL abandon the pending load, and no write SHALL occur for it.
REQ-026 in_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-027 When macro WB_FORWARD_EN is defined, fwd_valid, fwd_rd and fwd_data SHALL equal regWrite, writereg and writedata in the same cycle.
REQ-028 When WB_FORWARD_EN is undefined, fwd_valid, fwd_rd and fwd_data SHALL be constant 0 and no logic SHALL be generated for them.

Verification
REQ-029 The bench SHALL cover back-to-back non-loads: rd=5/0x11, rd=6/0x22 on consecutive cycles -> regWrite=1 on two consecutive cycles with writedata 0x11 then 0x22, and in_ready stays 1.
REQ-030 The bench SHALL cover sign-extended byte: LB, addr_lo=2, mem_rdata=0x12F03456 after 3 wait cycles -> writedata=0xFFFFFFF0, regWrite pulses once, in_ready=0 during the wait.
REQ-031 The bench SHALL cover halfword loads: LHU, addr_lo=2, rdata=0x8001ABCD -> 0x00008001; LH with the same inputs -> 0xFFFF8001.
REQ-032 The bench SHALL cover x0 and disabled writes: non-load with rd=0, and a load with in_regWrite=0 -> regWrite never asserts and in_ready returns to 1.
REQ-033 The bench SHALL cover timeout: TIMEOUT_CYCLES=4 and no mem_rvalid -> load_timeout=1 after 4 wait cycles, no write, IDLE; a later mem_rvalid is ignored.
REQ-034 The bench SHALL cover reset mid-load: reset asserted in WAIT_LOAD, then mem_rvalid -> all outputs 0 and no write.
